// File: rtl/dem_down_timer_if.sv
// Control/status bundle for dem_down_timer.
//   load, min_in, sec_in  : load request and minutes/seconds load values
//   start, pause          : run control
//   min_q, sec_q          : current registered minutes/seconds
//   running               : high while counting
//   br                    : one-cycle borrow pulse (seconds wrapped 00->59)
//   done                  : one-cycle pulse on reaching 00:00
// master drives the controls (system side), slave is the timer.
interface dem_down_timer_if;
    logic       load;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       start;
    logic       pause;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic       running;
    logic       br;
    logic       done;

    modport master (
        output load, min_in, sec_in, start, pause,
        input  min_q, sec_q, running, br, done
    );

    modport slave (
        input  load, min_in, sec_in, start, pause,
        output min_q, sec_q, running, br, done
    );
endinterface

// File: rtl/dem_down_timer.sv
// Loadable minutes:seconds countdown timer.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dem_down_timer_if.slave (load/min_in/sec_in/start/pause in,
//          min_q/sec_q/running/br/done out)
// A prescaler divides clk into second ticks; seconds decrement and borrow
// from minutes. Input priority within a cycle: rst > load > pause > start.
module dem_down_timer #(
    parameter int TICK_DIV = 20,
    parameter int MAX_VAL  = 59
) (
    input  logic                  clk,
    input  logic                  rst,
    dem_down_timer_if.slave       bus
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [5:0]    min_r, min_n, sec_r, sec_n;
    logic          br_n, done_n;
    logic          running_r, br_r, done_r;
    logic [5:0]    min_sat, sec_sat;
    logic          is_zero, tick;

    assign min_sat = (bus.min_in > 6'(MAX_VAL)) ? 6'(MAX_VAL) : bus.min_in;
    assign sec_sat = (bus.sec_in > 6'(MAX_VAL)) ? 6'(MAX_VAL) : bus.sec_in;
    assign is_zero = (min_r == '0) && (sec_r == '0);
    assign tick    = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pre       <= '0;
            min_r     <= '0;
            sec_r     <= '0;
            running_r <= 1'b0;
            br_r      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            pre       <= pre_n;
            min_r     <= min_n;
            sec_r     <= sec_n;
            running_r <= (state_n == RUN);
            br_r      <= br_n;
            done_r    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        pre_n   = pre;
        min_n   = min_r;
        sec_n   = sec_r;
        br_n    = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE, PAUSE: begin
                if (bus.load) begin
                    min_n   = min_sat;
                    sec_n   = sec_sat;
                    pre_n   = '0;
                    state_n = IDLE;
                end else if (bus.pause && state == PAUSE) begin
                    state_n = PAUSE;
                end else if (bus.start) begin
                    if (is_zero) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                // Pause freezes the prescaler phase and suppresses a
                // coincident tick; load is ignored while running.
                if (bus.pause) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    pre_n = '0;
                    if (sec_r != '0) begin
                        sec_n = sec_r - 6'd1;
                    end else if (min_r != '0) begin
                        sec_n = 6'(MAX_VAL);
                        min_n = min_r - 6'd1;
                        br_n  = 1'b1;
                    end
                    if (min_n == '0 && sec_n == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    pre_n = pre + PW'(1);
                end
            end
            DONE: begin
                if (bus.load) begin
                    min_n   = min_sat;
                    sec_n   = sec_sat;
                    pre_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.min_q   = min_r;
    assign bus.sec_q   = sec_r;
    assign bus.running = running_r;
    assign bus.br      = br_r;
    assign bus.done    = done_r;
endmodule

// File: doc/dem_down_timer.md
Name: dem_down_timer

Overview:
Loadable minutes:seconds countdown timer. It is the down-counting counterpart of the team's up-counter chain: a prescaler divides clk into second ticks, the seconds field decrements, and a borrow ripples into the minutes field. It raises a one-cycle done pulse on reaching 00:00. It sits beside the up-counters in the timing subsystem and feeds display and alarm logic.

Parameters:
TICK_DIV, 20, clk cycles per second tick (legal range 2..65535; prescaler counter width is clog2(TICK_DIV)).
MAX_VAL, 59, upper bound for both the minutes and seconds fields.

Ports:
clk      input   1  system clock; all logic is on the rising edge.
rst      input   1  synchronous, active-high reset.
load     input   1  load min_in/sec_in into the counter (level, sampled each edge).
min_in   input   6  minutes load value.
sec_in   input   6  seconds load value.
start    input   1  begin or resume the countdown.
pause    input   1  suspend the countdown; the prescaler phase is held.
min_q    output  6  current minutes, registered.
sec_q    output  6  current seconds, registered.
running  output  1  high while in RUN.
br       output  1  one-cycle pulse when seconds wrap 00->59 (borrow into minutes).
done     output  1  one-cycle pulse on reaching 00:00 or on a start with a zero value.

Behaviour:
- Reset, applied synchronously on any edge with rst=1 and overriding all other inputs:
  - min_q=0, sec_q=0, prescaler=0, state=IDLE.
  - running=0, br=0, done=0.
- States are IDLE, RUN, PAUSE and DONE. running = (state==RUN), registered alongside the state.
- Load is accepted in IDLE, PAUSE and DONE; it is ignored in RUN.
  - On load: min_q <= min(min_in,MAX_VAL); sec_q <= min(sec_in,MAX_VAL), so values above 59 saturate to 59.
  - Load also clears the prescaler and moves the state to IDLE, including from PAUSE and DONE.
- Start is accepted in IDLE and PAUSE.
  - If {min_q,sec_q} != 0, the state moves to RUN. From PAUSE the prescaler keeps its held value; from IDLE the prescaler is 0.
  - If the value is 00:00, the state moves to DONE and done pulses on the next cycle.
  - Start is ignored in RUN and DONE.
- Priority within one cycle: rst > load > pause > start.
  - load+start in IDLE: load applies and start is ignored; start must be reasserted.
  - pause+start in RUN or PAUSE: pause wins, and the state ends in PAUSE.
- In RUN, the prescaler counts 0..TICK_DIV-1 and wraps. A tick occurs on the cycle where prescaler==TICK_DIV-1, so the first tick lands TICK_DIV cycles after entering RUN from 0.
- On a tick, registered and effective at the same edge:
  - If sec_q>0: sec_q <= sec_q-1.
  - Else if min_q>0: sec_q <= MAX_VAL, min_q <= min_q-1, br <= 1.
  - If the post-tick value is 00:00: state <= DONE and done <= 1 on that same edge.
- br and done are high for exactly one cycle and otherwise 0. br never coincides with done, because a wrap always leaves sec_q=59.
- pause in RUN: state <= PAUSE. The prescaler and counters freeze; a tick that would occur on that same cycle is suppressed.
- DONE holds 00:00 with running=0 until load or rst. There is no auto-reload and no down-wrap below 00:00.
- There is no arithmetic underflow: the decrement is guarded by the >0 checks, and all fields are 6-bit unsigned.

Test Plan:
- Reset mid-run, TICK_DIV=4: load 01:30, start, run 10 cycles, assert rst for 1 cycle -> next edge min_q=0, sec_q=0, running=0, br=0, done=0, state IDLE.
- Basic countdown, TICK_DIV=4: load 00:03, start -> sec_q reads 2, 1, 0 at cycles 4, 8 and 12 after start; done=1 only in cycle 12; running=0 from cycle 12 on.
- Borrow, TICK_DIV=4: load 02:00, start -> at the first tick min_q=1, sec_q=59, br=1 for one cycle, done=0; at the 61st tick min_q=0, sec_q=59, br pulses again; at the 120th tick 00:00 with done pulsing.
- Pause/resume and ignored load, TICK_DIV=4:
  - Load 00:05, start, pause at cycle 6 -> sec_q stays 4 for 50 paused cycles with running=0.
  - Start again -> the next tick arrives 2 cycles later (held prescaler phase), sec_q=3.
  - A load pulsed during RUN leaves min_q/sec_q unchanged.
- Saturation and zero start: load min_in=63, sec_in=60 -> min_q=59, sec_q=59. Load 00:00, start -> done pulses once, state DONE; a further start leaves done=0 and running=0.
- Simultaneous inputs:
  - load+start in IDLE -> value loaded, running stays 0.
  - pause+start in RUN -> state PAUSE, running=0.
  - In DONE, load 00:02 -> state IDLE; start -> RUN again.
